// File: rtl/intrapred_mb_scheduler_pkg.sv
// Shared types and defaults for the intra-prediction macroblock scheduler.
package intrapred_pkg;
  localparam int MB_NUMBER_BITS_DFLT = 12;
  localparam int PIPE_DEPTH_DFLT     = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} sched_state_e;
endpackage

// File: rtl/intrapred_mb_scheduler_if.sv
// Frame control, issue and result handshake between the scheduler and its neighbours.
interface intrapred_mb_scheduler_if #(
  parameter int MB_NUMBER_BITS = intrapred_pkg::MB_NUMBER_BITS_DFLT,
  parameter int PIPE_DEPTH     = intrapred_pkg::PIPE_DEPTH_DFLT
);
  logic                      start;
  logic [7:0]                cfg_width_mbs;
  logic [7:0]                cfg_height_mbs;
  logic                      busy;
  logic                      done;
  logic [PIPE_DEPTH-1:0]     stage_en;
  logic [MB_NUMBER_BITS-1:0] issue_mbnumber;
  logic                      issue_top_avail;
  logic                      issue_left_avail;
  logic                      out_valid;
  logic                      out_ready;
  logic [MB_NUMBER_BITS-1:0] out_mbnumber;

  modport master (
    output start, cfg_width_mbs, cfg_height_mbs, out_ready,
    input  busy, done, stage_en, issue_mbnumber, issue_top_avail, issue_left_avail,
           out_valid, out_mbnumber
  );

  modport slave (
    input  start, cfg_width_mbs, cfg_height_mbs, out_ready,
    output busy, done, stage_en, issue_mbnumber, issue_top_avail, issue_left_avail,
           out_valid, out_mbnumber
  );
endinterface

// File: rtl/intrapred_mb_scheduler_stage_tracker.sv
// Per-stage valid bit and macroblock index, shifted one stage per advance.
module intrapred_stage_tracker import intrapred_pkg::*; #(
  parameter int MB_W  = MB_NUMBER_BITS_DFLT,
  parameter int DEPTH = PIPE_DEPTH_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             in_valid_i,
  input  logic [MB_W-1:0]  in_mb_i,
  output logic [DEPTH-1:0] valid_o,
  output logic [MB_W-1:0]  out_mb_o
);
  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][MB_W-1:0]  mb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      mb_q    <= '0;
    end else if (advance_i) begin
      valid_q <= {valid_q[DEPTH-2:0], in_valid_i};
      mb_q    <= {mb_q[DEPTH-2:0], in_mb_i};
    end
  end

  assign valid_o  = valid_q;
  assign out_mb_o = mb_q[DEPTH-1];
endmodule

// File: rtl/intrapred_mb_scheduler.sv
// Issues macroblocks of a frame in raster order into the intra-prediction
// pipeline, one per cycle, stalling the whole pipe on output backpressure.
module intrapred_mb_scheduler import intrapred_pkg::*; #(
  parameter int MB_NUMBER_BITS = MB_NUMBER_BITS_DFLT,
  parameter int PIPE_DEPTH     = PIPE_DEPTH_DFLT
) (
  input logic                     clk,
  input logic                     reset,
  intrapred_mb_scheduler_if.slave bus
);
  localparam int CW = (MB_NUMBER_BITS > 16) ? MB_NUMBER_BITS : 16;

  sched_state_e              state_q, state_d;
  logic [7:0]                width_q, col_q, row_q;
  logic [15:0]               total_q;
  logic [MB_NUMBER_BITS-1:0] issue_q;
  logic [PIPE_DEPTH-1:0]     valid;
  logic                      advance, issue, last_issue, drained, start_ok, empty_frame;

  assign advance     = !(bus.out_valid && !bus.out_ready);
  assign issue       = (state_q == RUN) && advance;
  assign last_issue  = (CW'(issue_q) == CW'(total_q) - CW'(1));
  assign start_ok    = (state_q == IDLE) && bus.start;
  assign empty_frame = (bus.cfg_width_mbs == 8'd0) || (bus.cfg_height_mbs == 8'd0);
  // Looks one edge ahead so done lands in the cycle right after the last output.
  assign drained     = advance && (valid[PIPE_DEPTH-2:0] == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = empty_frame ? FINISH : RUN;
      RUN:     if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (drained) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_q <= '0;
      total_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      issue_q <= '0;
    end else if (start_ok) begin
      width_q <= bus.cfg_width_mbs;
      total_q <= 16'(bus.cfg_width_mbs) * 16'(bus.cfg_height_mbs);
      col_q   <= '0;
      row_q   <= '0;
      issue_q <= '0;
    end else if (issue) begin
      issue_q <= issue_q + 1'b1;
      if (col_q == width_q - 8'd1) begin
        col_q <= '0;
        row_q <= row_q + 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

  always_comb begin
    bus.busy             = (state_q != IDLE);
    bus.done             = (state_q == FINISH);
    bus.stage_en         = '0;
    bus.stage_en[0]      = issue;
    for (int i = 1; i < PIPE_DEPTH; i++) bus.stage_en[i] = advance && valid[i-1];
    bus.issue_mbnumber   = '0;
    bus.issue_top_avail  = 1'b0;
    bus.issue_left_avail = 1'b0;
    if (state_q == RUN) begin
      bus.issue_mbnumber   = issue_q;
      bus.issue_top_avail  = (row_q != 8'd0);
      bus.issue_left_avail = (col_q != 8'd0);
    end
  end

  intrapred_stage_tracker #(.MB_W(MB_NUMBER_BITS), .DEPTH(PIPE_DEPTH)) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .advance_i  (advance),
    .in_valid_i (issue),
    .in_mb_i    (bus.issue_mbnumber),
    .valid_o    (valid),
    .out_mb_o   (bus.out_mbnumber)
  );

  assign bus.out_valid = valid[PIPE_DEPTH-1];
endmodule

// File: tb/tb_intrapred_mb_scheduler.sv
// Frame-level bench: table of frame shapes/stalls, raster model feeding a scoreboard.
module tb_intrapred_mb_scheduler;
  import intrapred_pkg::*;
  localparam int MBW = 12;
  localparam int PD  = 5;
  localparam int NV  = 8;

  typedef struct {
    int w; int h; int stall_mb; int stall_cycles; int restart_at; int exp_n; int exp_busy;
  } vec_t;
  typedef struct { int mb; int cyc; } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intrapred_mb_scheduler_if #(.MB_NUMBER_BITS(MBW), .PIPE_DEPTH(PD)) bus ();
  intrapred_mb_scheduler #(.MB_NUMBER_BITS(MBW), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .reset(rst), .bus(bus.slave)
  );

  int   n_chk = 0, n_fail = 0, cyc = 0;
  sb_t  sb[$];
  vec_t vt[NV];
  int   m_w, m_n, m_mb, m_col, m_row;
  int   busy_cnt, done_cnt, out_cnt, en_cnt, last_out_cyc, done_cyc, start_cyc;
  bit   lat_chk, prev_stall;
  int   prev_mb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     int'(bus.busy), 0);
    chk({tag, "_done"},     int'(bus.done), 0);
    chk({tag, "_stage_en"}, int'(bus.stage_en), 0);
    chk({tag, "_issue_mb"}, int'(bus.issue_mbnumber), 0);
    chk({tag, "_top"},      int'(bus.issue_top_avail), 0);
    chk({tag, "_left"},     int'(bus.issue_left_avail), 0);
    chk({tag, "_out_vld"},  int'(bus.out_valid), 0);
    chk({tag, "_out_mb"},   int'(bus.out_mbnumber), 0);
    chk({tag, "_state"},    int'(dut.state_q), int'(IDLE));
  endtask

  // Monitor: raster model on issue, scoreboard pop on output handshake.
  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst) begin
      if (bus.stage_en != '0) en_cnt++;
      if (bus.stage_en[0]) begin
        chk("issue_mb",       int'(bus.issue_mbnumber), m_mb);
        chk("top_avail",      int'(bus.issue_top_avail), int'(m_row != 0));
        chk("left_avail",     int'(bus.issue_left_avail), int'(m_col != 0));
        chk("issue_in_range", int'(m_mb < m_n), 1);
        sb.push_back('{mb: m_mb, cyc: cyc});
        m_mb++;
        if (m_col == m_w - 1) begin m_col = 0; m_row++; end
        else m_col++;
      end
      if (prev_stall) begin
        chk("stall_hold_valid", int'(bus.out_valid), 1);
        chk("stall_hold_mb",    int'(bus.out_mbnumber), prev_mb);
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_no_en", int'(bus.stage_en), 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_mb", int'(bus.out_mbnumber), e.mb);
          if (lat_chk) chk("latency", cyc - e.cyc, PD);
        end
        out_cnt++;
        last_out_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_mb    = int'(bus.out_mbnumber);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic model_reset(input int w, input int h);
    m_w = w; m_n = w * h; m_mb = 0; m_col = 0; m_row = 0;
    busy_cnt = 0; done_cnt = 0; out_cnt = 0; en_cnt = 0;
    last_out_cyc = 0; done_cyc = 0;
    sb.delete();
  endtask

  task automatic run_frame(input vec_t v);
    int budget, stall_left;
    bit restarted;
    model_reset(v.w, v.h);
    lat_chk    = (v.stall_cycles == 0);
    stall_left = v.stall_cycles;
    restarted  = 1'b0;
    bus.cfg_width_mbs  = 8'(v.w);
    bus.cfg_height_mbs = 8'(v.h);
    bus.out_ready      = 1'b1;
    bus.start          = 1'b1;
    start_cyc          = cyc;
    @(posedge clk); #1;
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      bus.start         = 1'b0;
      bus.cfg_width_mbs = 8'(v.w);
      // A mid-frame start with a different width must be ignored.
      if (!restarted && v.restart_at >= 0 && m_mb == v.restart_at) begin
        bus.start         = 1'b1;
        bus.cfg_width_mbs = 8'(v.w + 1);
        restarted         = 1'b1;
      end
      if (stall_left > 0 && bus.out_valid && int'(bus.out_mbnumber) == v.stall_mb) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    chk("frame_done_seen", int'(done_cnt != 0), 1);
    chk("issued",          m_mb, v.exp_n);
    chk("outputs",         out_cnt, v.exp_n);
    chk("busy_cycles",     busy_cnt, v.exp_busy);
    chk("sb_empty",        sb.size(), 0);
    chk("idle_after_done", int'(bus.busy), 0);
    chk("done_single",     int'(bus.done), 0);
    if (v.exp_n == 0) begin
      chk("empty_no_stage_en", en_cnt, 0);
      chk("empty_done_lat",    done_cyc - start_cyc, 1);
    end else begin
      chk("done_after_last",   done_cyc - last_out_cyc, 1);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_width_mbs = '0; bus.cfg_height_mbs = '0; bus.out_ready = 1'b1;
    model_reset(0, 0);
    prev_stall = 1'b0; prev_mb = 0; lat_chk = 1'b0; start_cyc = 0;

    //           w   h  stall_mb stall_cyc restart  n   busy
    vt[0] = '{   2,  2, -1,      0,        -1,      4,  10};
    vt[1] = '{   3,  1,  0,      3,        -1,      3,  12};
    vt[2] = '{   0,  3, -1,      0,        -1,      0,  1};
    vt[3] = '{   4,  4, -1,      0,         5,     16,  22};
    vt[4] = '{   5,  0, -1,      0,        -1,      0,  1};
    vt[5] = '{   1,  1, -1,      0,        -1,      1,  7};
    vt[6] = '{   3,  2,  4,      2,        -1,      6,  14};
    vt[7] = '{  16, 16, -1,      0,        -1,    256,  262};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: each frame starts the cycle after the previous done.
    for (int i = 0; i < NV; i++) run_frame(vt[i]);

    // Reset mid-frame aborts with no done pulse.
    model_reset(4, 4);
    lat_chk = 1'b1;
    bus.cfg_width_mbs = 8'd4; bus.cfg_height_mbs = 8'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    budget = 0;
    while (m_mb < 5 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("abort_reached_5", int'(m_mb >= 5), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("abort");
    rst = 1'b0;
    model_reset(4, 4);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_stays_idle", busy_cnt, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; bus.start = 1'b1; bus.cfg_width_mbs = 8'd2; bus.cfg_height_mbs = 8'd2;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_over_start_busy", int'(bus.busy), 0);
    model_reset(2, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_over_start_idle", busy_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
